// File: rtl/multicycle_control.sv
// multicycle_control: multicycle CPU control FSM; in CLK, Reset (async active-low), opcode, zero; out state, PCWre, PCSrc, IRWre, RegWre, ALUSrcA, ALUSrcB, mRD, mWR, DBDataSrc, ExtSel, WrRegDSrc, RegDst, ALUOp, halted
module multicycle_control #(
  parameter logic [5:0] HALT_OP = 6'b111111
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic [3:0] state,
  output logic       PCWre,
  output logic [1:0] PCSrc,
  output logic       IRWre,
  output logic       RegWre,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic       mRD,
  output logic       mWR,
  output logic       DBDataSrc,
  output logic       ExtSel,
  output logic       WrRegDSrc,
  output logic [1:0] RegDst,
  output logic [2:0] ALUOp,
  output logic       halted
);
  localparam logic [3:0] S_IF = 4'b0000, S_ID = 4'b0001, S_EXE_AL = 4'b0110, S_EXE_BR = 4'b0101,
                         S_EXE_LS = 4'b0010, S_MEM = 4'b0011, S_WB_AL = 4'b0111, S_WB_LD = 4'b0100,
                         S_HALT = 4'b1000;
  localparam logic [5:0] OP_ADD = 6'b000000, OP_SUB = 6'b000001, OP_ADDI = 6'b000010, OP_ORI = 6'b010010,
                         OP_SW = 6'b110000, OP_LW = 6'b110001, OP_BEQ = 6'b110100, OP_BNE = 6'b110101,
                         OP_J = 6'b111000, OP_JR = 6'b111001, OP_JAL = 6'b111010;
  logic [5:0] op, dop;
  logic [3:0] next_state;
  logic is_al, is_br, is_ls, is_halt;
  assign dop = (state == S_ID) ? opcode : op;
  assign is_al = dop == OP_ADD || dop == OP_SUB || dop == OP_ADDI || dop == OP_ORI;
  assign is_br = dop == OP_BEQ || dop == OP_BNE;
  assign is_ls = dop == OP_SW || dop == OP_LW;
  assign is_halt = dop == HALT_OP && !(is_al || is_br || is_ls);
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state <= S_IF;
      op <= 6'b000000;
    end else begin
      state <= next_state;
      if (state == S_ID) op <= opcode;
    end
  end
  always_comb begin
    next_state = S_IF;
    PCWre = 1'b0;
    PCSrc = 2'b00;
    IRWre = 1'b0;
    RegWre = 1'b0;
    ALUSrcA = 1'b0;
    ALUSrcB = 1'b0;
    mRD = 1'b0;
    mWR = 1'b0;
    DBDataSrc = 1'b0;
    ExtSel = 1'b0;
    WrRegDSrc = 1'b0;
    RegDst = 2'b00;
    ALUOp = 3'b000;
    halted = 1'b0;
    case (state)
      S_IF: begin
        IRWre = 1'b1;
        next_state = S_ID;
      end
      S_ID: begin
        next_state = is_al ? S_EXE_AL : is_br ? S_EXE_BR : is_ls ? S_EXE_LS : is_halt ? S_HALT : S_IF;
        PCWre = !(is_al || is_br || is_ls || is_halt);
        PCSrc = (dop == OP_J || dop == OP_JAL) ? 2'b11 : (dop == OP_JR) ? 2'b10 : 2'b00;
        RegWre = dop == OP_JAL;
      end
      S_EXE_AL: begin
        next_state = S_WB_AL;
        ALUOp = (dop == OP_SUB) ? 3'b001 : (dop == OP_ORI) ? 3'b011 : 3'b000;
        ALUSrcB = dop == OP_ADDI || dop == OP_ORI;
        ExtSel = dop != OP_ORI;
      end
      S_EXE_BR: begin
        ALUOp = 3'b001;
        ExtSel = 1'b1;
        PCWre = 1'b1;
        PCSrc = {1'b0, (dop == OP_BEQ && zero) || (dop == OP_BNE && !zero)};
      end
      S_EXE_LS: begin
        next_state = S_MEM;
        ALUSrcB = 1'b1;
        ExtSel = 1'b1;
      end
      S_MEM: begin
        next_state = (dop == OP_LW) ? S_WB_LD : S_IF;
        mWR = dop == OP_SW;
        mRD = dop == OP_LW;
        PCWre = dop == OP_SW;
      end
      S_WB_AL: begin
        RegWre = 1'b1;
        WrRegDSrc = 1'b1;
        RegDst = (dop == OP_ADD || dop == OP_SUB) ? 2'b10 : 2'b01;
        PCWre = 1'b1;
      end
      S_WB_LD: begin
        RegWre = 1'b1;
        DBDataSrc = 1'b1;
        WrRegDSrc = 1'b1;
        RegDst = 2'b01;
        PCWre = 1'b1;
      end
      S_HALT: begin
        halted = 1'b1;
        next_state = S_HALT;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed self-checking bench for multicycle_control
module tb_multicycle_control;
  logic CLK = 1'b0, Reset = 1'b0, zero = 1'b0;
  logic [5:0] opcode = 6'b000000;
  logic [3:0] state;
  logic PCWre, IRWre, RegWre, ALUSrcA, ALUSrcB, mRD, mWR, DBDataSrc, ExtSel, WrRegDSrc, halted;
  logic [1:0] PCSrc, RegDst;
  logic [2:0] ALUOp;
  int n_chk = 0, n_fail = 0;
  multicycle_control dut (
    .CLK(CLK), .Reset(Reset), .opcode(opcode), .zero(zero), .state(state), .PCWre(PCWre), .PCSrc(PCSrc),
    .IRWre(IRWre), .RegWre(RegWre), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .mRD(mRD), .mWR(mWR),
    .DBDataSrc(DBDataSrc), .ExtSel(ExtSel), .WrRegDSrc(WrRegDSrc), .RegDst(RegDst), .ALUOp(ALUOp),
    .halted(halted)
  );
  always #5 CLK = ~CLK;
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  task automatic test_reset();
    #12;
    n_chk++; if (state !== 4'h0) begin n_fail++; $display("FAIL rst.state got %h exp 0", state); end
    n_chk++; if (IRWre !== 1'b1) begin n_fail++; $display("FAIL rst.IRWre got %b exp 1", IRWre); end
    n_chk++; if ({PCWre, RegWre, mWR, halted} !== 4'b0) begin n_fail++; $display("FAIL rst.wr got %b exp 0000", {PCWre, RegWre, mWR, halted}); end
    @(negedge CLK);
    n_chk++; if (state !== 4'h0) begin n_fail++; $display("FAIL rst.hold got %h exp 0", state); end
    Reset = 1'b1;
  endtask
  task automatic test_add();
    logic [3:0] es;
    opcode = 6'b000000;
    for (int i = 0; i < 4; i++) begin
      es = i == 0 ? 4'h0 : i == 1 ? 4'h1 : i == 2 ? 4'h6 : 4'h7;
      n_chk++; if (state !== es) begin n_fail++; $display("FAIL add.state[%0d] got %h exp %h", i, state, es); end
      n_chk++; if (PCWre !== (i == 3)) begin n_fail++; $display("FAIL add.PCWre[%0d] got %b", i, PCWre); end
      n_chk++; if (RegWre !== (i == 3)) begin n_fail++; $display("FAIL add.RegWre[%0d] got %b", i, RegWre); end
      n_chk++; if (IRWre !== (i == 0)) begin n_fail++; $display("FAIL add.IRWre[%0d] got %b", i, IRWre); end
      if (i == 3) begin
        n_chk++; if ({PCSrc, RegDst, DBDataSrc} !== 5'b00100) begin n_fail++; $display("FAIL add.wb got %b exp 00100", {PCSrc, RegDst, DBDataSrc}); end
      end
      @(negedge CLK);
    end
  endtask
  task automatic test_ori();
    opcode = 6'b010010;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        n_chk++; if ({ALUOp, ALUSrcB, ExtSel} !== 5'b01110) begin n_fail++; $display("FAIL ori.exe got %b exp 01110", {ALUOp, ALUSrcB, ExtSel}); end
      end
      if (i == 3) begin
        n_chk++; if ({state, RegWre, RegDst, PCWre} !== 8'b0111_1011) begin n_fail++; $display("FAIL ori.wb got %b exp 01111011", {state, RegWre, RegDst, PCWre}); end
      end
      @(negedge CLK);
    end
  endtask
  task automatic test_lw();
    logic [3:0] es;
    opcode = 6'b110001;
    for (int i = 0; i < 5; i++) begin
      es = i == 0 ? 4'h0 : i == 1 ? 4'h1 : i == 2 ? 4'h2 : i == 3 ? 4'h3 : 4'h4;
      n_chk++; if (state !== es) begin n_fail++; $display("FAIL lw.state[%0d] got %h exp %h", i, state, es); end
      n_chk++; if (PCWre !== (i == 4)) begin n_fail++; $display("FAIL lw.PCWre[%0d] got %b", i, PCWre); end
      n_chk++; if (mRD !== (i == 3)) begin n_fail++; $display("FAIL lw.mRD[%0d] got %b", i, mRD); end
      n_chk++; if (RegWre !== (i == 4)) begin n_fail++; $display("FAIL lw.RegWre[%0d] got %b", i, RegWre); end
      if (i == 2) begin
        n_chk++; if ({ALUSrcB, ExtSel, ALUOp} !== 5'b11000) begin n_fail++; $display("FAIL lw.exe got %b exp 11000", {ALUSrcB, ExtSel, ALUOp}); end
      end
      if (i == 4) begin
        n_chk++; if ({DBDataSrc, RegDst, PCSrc} !== 5'b10100) begin n_fail++; $display("FAIL lw.wb got %b exp 10100", {DBDataSrc, RegDst, PCSrc}); end
      end
      @(negedge CLK);
    end
  endtask
  task automatic test_sw();
    logic [3:0] es;
    opcode = 6'b110000;
    for (int i = 0; i < 4; i++) begin
      es = i == 0 ? 4'h0 : i == 1 ? 4'h1 : i == 2 ? 4'h2 : 4'h3;
      n_chk++; if (state !== es) begin n_fail++; $display("FAIL sw.state[%0d] got %h exp %h", i, state, es); end
      n_chk++; if ({mWR, PCWre} !== {2{i == 3}}) begin n_fail++; $display("FAIL sw.wr[%0d] got %b", i, {mWR, PCWre}); end
      n_chk++; if (RegWre !== 1'b0) begin n_fail++; $display("FAIL sw.RegWre[%0d] got %b exp 0", i, RegWre); end
      @(negedge CLK);
    end
  endtask
  task automatic test_branch();
    logic [1:0] ep;
    for (int k = 0; k < 4; k++) begin
      opcode = k < 2 ? 6'b110100 : 6'b110101;
      zero = k[0];
      ep = ((k < 2) == k[0]) ? 2'b01 : 2'b00;
      for (int i = 0; i < 3; i++) begin
        n_chk++; if (state !== (i == 0 ? 4'h0 : i == 1 ? 4'h1 : 4'h5)) begin n_fail++; $display("FAIL br%0d.state[%0d] got %h", k, i, state); end
        n_chk++; if (PCWre !== (i == 2)) begin n_fail++; $display("FAIL br%0d.PCWre[%0d] got %b", k, i, PCWre); end
        if (i == 2) begin
          n_chk++; if (PCSrc !== ep) begin n_fail++; $display("FAIL br%0d.PCSrc got %b exp %b", k, PCSrc, ep); end
          n_chk++; if (ALUOp !== 3'b001) begin n_fail++; $display("FAIL br%0d.ALUOp got %b exp 001", k, ALUOp); end
        end
        @(negedge CLK);
      end
    end
    zero = 1'b0;
  endtask
  task automatic test_jumps();
    logic [1:0] ep;
    for (int k = 0; k < 3; k++) begin
      opcode = k == 0 ? 6'b111000 : k == 1 ? 6'b111001 : 6'b111010;
      ep = k == 1 ? 2'b10 : 2'b11;
      n_chk++; if (state !== 4'h0) begin n_fail++; $display("FAIL j%0d.if got %h exp 0", k, state); end
      @(negedge CLK);
      n_chk++; if ({state, PCWre, PCSrc} !== {4'h1, 1'b1, ep}) begin n_fail++; $display("FAIL j%0d.id got %b exp %b", k, {state, PCWre, PCSrc}, {4'h1, 1'b1, ep}); end
      n_chk++; if (RegWre !== (k == 2)) begin n_fail++; $display("FAIL j%0d.RegWre got %b", k, RegWre); end
      if (k == 2) begin
        n_chk++; if ({RegDst, WrRegDSrc} !== 3'b000) begin n_fail++; $display("FAIL jal.dst got %b exp 000", {RegDst, WrRegDSrc}); end
      end
      @(negedge CLK);
    end
  endtask
  task automatic test_illegal();
    opcode = 6'b000011;
    @(negedge CLK);
    n_chk++; if ({state, PCWre, PCSrc, RegWre} !== 8'b0001_1000) begin n_fail++; $display("FAIL ill.id got %b exp 00011000", {state, PCWre, PCSrc, RegWre}); end
    @(negedge CLK);
    n_chk++; if (state !== 4'h0) begin n_fail++; $display("FAIL ill.next got %h exp 0", state); end
  endtask
  task automatic test_back_to_back();
    for (int k = 0; k < 2; k++) begin
      opcode = k == 0 ? 6'b000010 : 6'b000001;
      for (int i = 0; i < 4; i++) begin
        n_chk++; if (state !== (i == 0 ? 4'h0 : i == 1 ? 4'h1 : i == 2 ? 4'h6 : 4'h7)) begin n_fail++; $display("FAIL b2b%0d.state[%0d] got %h", k, i, state); end
        if (i == 2) begin
          n_chk++; if ({ALUOp, ALUSrcB} !== (k == 0 ? 4'b0001 : 4'b0010)) begin n_fail++; $display("FAIL b2b%0d.exe got %b", k, {ALUOp, ALUSrcB}); end
        end
        if (i == 3) begin
          n_chk++; if (RegDst !== (k == 0 ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL b2b%0d.RegDst got %b", k, RegDst); end
        end
        @(negedge CLK);
      end
    end
  endtask
  task automatic test_halt();
    opcode = 6'b111111;
    @(negedge CLK);
    n_chk++; if ({state, PCWre} !== 5'b0001_0) begin n_fail++; $display("FAIL halt.id got %b exp 00010", {state, PCWre}); end
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      n_chk++; if ({state, halted, PCWre, RegWre, mWR, IRWre} !== 9'b1000_10000) begin n_fail++; $display("FAIL halt.hold[%0d] got %b exp 100010000", i, {state, halted, PCWre, RegWre, mWR, IRWre}); end
    end
    opcode = 6'b000000;
    Reset = 1'b0;
    #1;
    n_chk++; if ({state, halted, IRWre} !== 6'b0000_01) begin n_fail++; $display("FAIL halt.rst got %b exp 000001", {state, halted, IRWre}); end
    @(negedge CLK);
    Reset = 1'b1;
    @(negedge CLK);
    n_chk++; if (state !== 4'h1) begin n_fail++; $display("FAIL halt.resume got %h exp 1", state); end
    @(negedge CLK);
    @(negedge CLK);
    @(negedge CLK);
  endtask
  task automatic test_reset_mid_sw();
    opcode = 6'b110000;
    repeat (3) @(negedge CLK);
    n_chk++; if ({state, mWR} !== 5'b0011_1) begin n_fail++; $display("FAIL rsw.mem got %b exp 00111", {state, mWR}); end
    #2 Reset = 1'b0;
    #1;
    n_chk++; if ({state, mWR, PCWre} !== 6'b0) begin n_fail++; $display("FAIL rsw.async got %b exp 000000", {state, mWR, PCWre}); end
    @(posedge CLK);
    #1;
    n_chk++; if ({state, PCWre} !== 5'b0) begin n_fail++; $display("FAIL rsw.hold got %b exp 00000", {state, PCWre}); end
    @(negedge CLK);
    Reset = 1'b1;
    opcode = 6'b111000;
    @(negedge CLK);
    n_chk++; if ({state, PCSrc} !== 6'b0001_11) begin n_fail++; $display("FAIL rsw.after got %b exp 000111", {state, PCSrc}); end
    @(negedge CLK);
  endtask
  initial begin
    test_reset();
    test_add();
    test_ori();
    test_lw();
    test_sw();
    test_branch();
    test_jumps();
    test_illegal();
    test_back_to_back();
    test_halt();
    test_reset_mid_sw();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
